iommu_msi_arbiter: RTL and testbench
====================================

// Module: iommu_msi_arbiter
// PURPOSE
//  Schedules MSI generation for all IOMMU interrupt sources (CQ, FQ, HPM, PQ) onto one MSI write engine.
//  Per source: detects the rising edge of the pending bit and latches a pending message.
//  Holds the message while its vector is masked; grants round-robin among unmasked pending sources.
//  Sits between the register file (ip/iv bits, MSI config table) and the AXI MSI write engine (req/done handshake).
// PARAMETERS
//  N_SRC   4   number of interrupt sources; index 0=CQ,1=FQ,2=HPM,3=PQ
//  N_VEC   16  MSI config table entries; vector index width = $clog2(N_VEC)
//  ADDR_W  56  MSI byte address width; table holds ADDR_W-2 bits, low 2 bits zero
//  DATA_W  32  MSI data width
// PORTS
//  clk_i               in   1                  clock
//  rst_i               in   1                  asynchronous active-high reset
//  msi_ig_enabled_i    in   1                  1 = MSI is the selected IG mechanism
//  ip_i                in   N_SRC              interrupt-pending bits (level)
//  iv_i                in   N_SRC x log2N_VEC  vector index per source
//  msi_addr_x_i        in   N_VEC x ADDR_W-2   MSI table address[ADDR_W-1:2]
//  msi_data_x_i        in   N_VEC x DATA_W     MSI table data
//  msi_vec_masked_x_i  in   N_VEC              vector mask bits
//  wr_valid_o          out  1                  MSI write request valid
//  wr_ready_i          in   1                  engine accepts request
//  wr_addr_o           out  ADDR_W             {table addr, 2'b00}, latched at grant
//  wr_data_o           out  DATA_W             latched at grant
//  wr_done_i           in   1                  1-cycle pulse: write completed OKAY
//  wr_error_i          in   1                  1-cycle pulse: write completed with error
//  pending_o           out  N_SRC              pending-message bits (debug/status)
//  busy_o              out  1                  state != IDLE
//  msi_write_error_o   out  1                  1-cycle error pulse
//  err_src_o           out  log2N_SRC          source of last error; valid with the pulse, held after
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; ip_prev_q, pending_q, rr pointer (last-grant idx) = 0.
//  Edge detect:
//   - ip_prev_q <= ip_i every cycle, regardless of enable.
//   - rise[i] = ip_i[i] & ~ip_prev_q[i].
//  Pending set/clear:
//   - pending_q[i] set on rise[i] when msi_ig_enabled_i=1; rises while disabled are dropped.
//   - Disable does not clear existing pending bits.
//   - pending_q[i] cleared on wr_valid_o&wr_ready_i for granted source i.
//   - Set and clear of the same bit in the same cycle: set wins (message re-queued).
//  Eligibility: elig[i] = pending_q[i] & ~msi_vec_masked_x_i[iv_i[i]], using live iv_i and mask.
//   - Masked messages stay pending, and issue the cycle after the mask clears.
//  FSM IDLE:
//   - If enabled and |elig: grant the first eligible index after the rr pointer (wrapping N_SRC-1 -> 0).
//   - Latch addr/data/src from msi_*_x_i[iv_i[g]]; rr pointer <= g; -> ISSUE.
//   - Grant decision: 1 cycle.
//  FSM ISSUE:
//   - wr_valid_o=1; addr/data held stable until wr_ready_i.
//   - On handshake -> WAIT; pending bit cleared that cycle.
//   - Valid is never withdrawn, even if enable drops.
//  FSM WAIT:
//   - On wr_done_i -> IDLE.
//   - On wr_error_i -> IDLE; msi_write_error_o=1 for 1 cycle; err_src_o <= src. Message is not retried.
//   - done and error in the same cycle: error wins.
//  Throughput: at most one MSI in flight; next grant evaluated in the IDLE cycle after completion.
//  Reset mid-operation: returns to IDLE immediately; wr_valid_o drops asynchronously. Engine shares rst_i.
//  iv_i or table change after grant: no effect on the latched request.
// STRUCTURE
//  iommu_pkg:
//   - localparams SRC_CQ/SRC_FQ/SRC_HPM/SRC_PQ and MSI_N_VEC.
//   - typedef msi_req_t {addr, data, src}.
//   - enum msi_arb_state_e {IDLE, ISSUE, WAIT}.
//  Sub-module iommu_rr_arb:
//   - Parameterised N-way round-robin arbiter (req vector, ptr in -> one-hot/idx grant, valid).
//   - Purely combinational; pointer register lives in the parent.
// TESTING
//  1 CQ: iv=3, tbl[3]={addr=0x1000>>2, data=0xA5}; ip[0] rises -> wr_valid_o, addr=0x1000, data=0xA5; done -> IDLE, pending_o=0.
//  2 Mask: FQ vec 5 masked, ip[1] rises -> no req, pending_o[1]=1; unmask -> req on the next cycle.
//  3 RR: CQ, FQ, HPM rise in the same cycle, ptr=0 -> grants FQ, HPM, CQ in that order, 3 writes.
//  4 Error: wr_error_i in WAIT -> msi_write_error_o 1-cycle pulse, err_src_o=src, pending cleared, no retry.
//  5 Re-rise: ip[0] falls and rises during WAIT -> pending re-set, second MSI after done.
//  6 Disabled: rise with enable=0 -> no pending, no req; wr_ready_i held 0 in ISSUE -> addr/data stable; rst_i mid-WAIT -> IDLE, all 0.

Source files
------------

// File: rtl/iommu_pkg.sv
// iommu_pkg: shared constants and types for the IOMMU MSI path.
//   - source indices for the four interrupt sources
//   - default MSI geometry (table size, address and data widths)
//   - msi_req_t: one latched MSI write request
//   - msi_arb_state_e: MSI arbiter FSM states
package iommu_pkg;

  localparam int SRC_CQ  = 0;
  localparam int SRC_FQ  = 1;
  localparam int SRC_HPM = 2;
  localparam int SRC_PQ  = 3;

  localparam int MSI_N_SRC  = 4;
  localparam int MSI_N_VEC  = 16;
  localparam int MSI_ADDR_W = 56;
  localparam int MSI_DATA_W = 32;
  localparam int MSI_SRC_W  = $clog2(MSI_N_SRC);

  typedef struct packed {
    logic [MSI_ADDR_W-1:0] addr;
    logic [MSI_DATA_W-1:0] data;
    logic [MSI_SRC_W-1:0]  src;
  } msi_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } msi_arb_state_e;

endpackage

// File: rtl/iommu_rr_arb.sv
// iommu_rr_arb: combinational N-way round-robin arbiter.
// The search starts at the index just after ptr and wraps from N-1 to 0,
// so the last winner has the lowest priority. The pointer register lives
// in the parent.
// Ports:
//   req        in   N       request vector
//   ptr        in   IDX_W   index of the last grant
//   gnt_oh     out  N       one-hot grant
//   gnt_idx    out  IDX_W   binary grant index
//   gnt_valid  out  1       at least one request was granted
module iommu_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  always_comb begin
    int j;
    j         = 0;
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int off = 1; off <= N; off++) begin
      j = (int'(ptr) + off) % N;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt_oh[j] = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/iommu_msi_arbiter.sv
// iommu_msi_arbiter: schedules MSI writes for the CQ, FQ, HPM and PQ
// interrupt sources onto a single MSI write engine.
// A rising edge of a source's ip bit (while MSI is enabled) latches a
// pending message. Pending messages whose vector is masked are held;
// unmasked ones are granted round-robin, one write in flight at a time.
// The request (address, data, source) is latched at grant, so later
// changes to iv_i or the MSI table do not affect it.
// The parameters must match the widths in iommu_pkg::msi_req_t.
//
//   state | meaning
//   IDLE  | no write in flight; grant the next eligible source
//   ISSUE | wr_valid_o high, waiting for wr_ready_i
//   WAIT  | request accepted, waiting for wr_done_i / wr_error_i
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   msi_ig_enabled_i      MSI is the selected interrupt mechanism
//   ip_i, iv_i            pending bits and vector index per source
//   msi_addr_x_i/data     MSI config table (address bits [ADDR_W-1:2])
//   msi_vec_masked_x_i    per-vector mask bits
//   wr_valid_o/ready_i    request handshake to the write engine
//   wr_addr_o, wr_data_o  latched request
//   wr_done_i, wr_error_i completion pulses from the engine
//   pending_o, busy_o     status
//   msi_write_error_o     one-cycle pulse on an errored write
//   err_src_o             source of the last errored write (held)
module iommu_msi_arbiter
  import iommu_pkg::*;
#(
  parameter int N_SRC  = MSI_N_SRC,
  parameter int N_VEC  = MSI_N_VEC,
  parameter int ADDR_W = MSI_ADDR_W,
  parameter int DATA_W = MSI_DATA_W,
  parameter int VEC_W  = $clog2(N_VEC),
  parameter int SRC_W  = $clog2(N_SRC)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          msi_ig_enabled_i,
  input  logic [N_SRC-1:0]              ip_i,
  input  logic [N_SRC-1:0][VEC_W-1:0]   iv_i,
  input  logic [N_VEC-1:0][ADDR_W-3:0]  msi_addr_x_i,
  input  logic [N_VEC-1:0][DATA_W-1:0]  msi_data_x_i,
  input  logic [N_VEC-1:0]              msi_vec_masked_x_i,
  output logic                          wr_valid_o,
  input  logic                          wr_ready_i,
  output logic [ADDR_W-1:0]             wr_addr_o,
  output logic [DATA_W-1:0]             wr_data_o,
  input  logic                          wr_done_i,
  input  logic                          wr_error_i,
  output logic [N_SRC-1:0]              pending_o,
  output logic                          busy_o,
  output logic                          msi_write_error_o,
  output logic [SRC_W-1:0]              err_src_o
);

  msi_arb_state_e   state_q;
  msi_req_t         req_q;
  logic [N_SRC-1:0] req_oh_q;
  logic [SRC_W-1:0] rr_ptr_q;
  logic [N_SRC-1:0] ip_prev_q;
  logic [N_SRC-1:0] pending_q;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] set_pend;
  logic [N_SRC-1:0] clr_pend;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] gnt_oh;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             handshake;

  assign rise      = ip_i & ~ip_prev_q;
  assign set_pend  = rise & {N_SRC{msi_ig_enabled_i}};
  assign handshake = (state_q == ISSUE) && wr_ready_i;
  assign clr_pend  = req_oh_q & {N_SRC{handshake}};
  // Set after clear: a new edge in the handshake cycle re-queues the message.
  assign pending_d = (pending_q & ~clr_pend) | set_pend;

  // Uses the live mask and vector index, so an unmask is seen immediately.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SRC; i++) begin
      elig[i] = pending_q[i] & ~msi_vec_masked_x_i[iv_i[i]];
    end
  end

  iommu_rr_arb #(
    .N     (N_SRC),
    .IDX_W (SRC_W)
  ) u_rr_arb (
    .req       (elig),
    .ptr       (rr_ptr_q),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      req_q             <= '0;
      req_oh_q          <= '0;
      rr_ptr_q          <= '0;
      ip_prev_q         <= '0;
      pending_q         <= '0;
      wr_valid_o        <= 1'b0;
      msi_write_error_o <= 1'b0;
      err_src_o         <= '0;
    end else begin
      ip_prev_q         <= ip_i;
      pending_q         <= pending_d;
      msi_write_error_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (msi_ig_enabled_i && gnt_valid) begin
            req_q.addr <= {msi_addr_x_i[iv_i[gnt_idx]], 2'b00};
            req_q.data <= msi_data_x_i[iv_i[gnt_idx]];
            req_q.src  <= gnt_idx;
            req_oh_q   <= gnt_oh;
            rr_ptr_q   <= gnt_idx;
            wr_valid_o <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // Once raised, valid stays up until accepted, even if MSI is disabled.
          if (wr_ready_i) begin
            wr_valid_o <= 1'b0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (wr_error_i) begin
            msi_write_error_o <= 1'b1;
            err_src_o         <= req_q.src;
            state_q           <= IDLE;
          end else if (wr_done_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          wr_valid_o <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign wr_addr_o = req_q.addr;
  assign wr_data_o = req_q.data;
  assign pending_o = pending_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_iommu_msi_arbiter.sv
module tb_iommu_msi_arbiter;

  logic                clk;
  logic                rst;
  logic                en;
  logic [3:0]          ip;
  logic [3:0][3:0]     iv;
  logic [15:0][53:0]   tbl_addr;
  logic [15:0][31:0]   tbl_data;
  logic [15:0]         mask;
  logic                wr_valid;
  logic                wr_ready;
  logic [55:0]         wr_addr;
  logic [31:0]         wr_data;
  logic                wr_done;
  logic                wr_error;
  logic [3:0]          pending;
  logic                busy;
  logic                err_pulse;
  logic [1:0]          err_src;

  iommu_msi_arbiter dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .msi_ig_enabled_i   (en),
    .ip_i               (ip),
    .iv_i               (iv),
    .msi_addr_x_i       (tbl_addr),
    .msi_data_x_i       (tbl_data),
    .msi_vec_masked_x_i (mask),
    .wr_valid_o         (wr_valid),
    .wr_ready_i         (wr_ready),
    .wr_addr_o          (wr_addr),
    .wr_data_o          (wr_data),
    .wr_done_i          (wr_done),
    .wr_error_i         (wr_error),
    .pending_o          (pending),
    .busy_o             (busy),
    .msi_write_error_o  (err_pulse),
    .err_src_o          (err_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [55:0] addr;
    logic [31:0] data;
    int          src;
  } exp_t;

  typedef struct {
    int          src;
    logic [3:0]  vec;
    logic [53:0] t_addr;
    logic [31:0] t_data;
    logic [55:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  vec_t vecs[4];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int s);
    exp_t e;
    e.src  = s;
    e.addr = {tbl_addr[iv[s]], 2'b00};
    e.data = tbl_data[iv[s]];
    sb.push_back(e);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (wr_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 64'(wr_valid), 1);
    if (wr_valid === 1'b1) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        last_exp = sb.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(last_exp.addr));
        chk("wr_data", 64'(wr_data), 64'(last_exp.data));
      end
    end
  endtask

  task automatic handshake();
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    chk("valid_drop", 64'(wr_valid), 0);
    chk("busy_wait", 64'(busy), 1);
  endtask

  task automatic complete(input bit err);
    wr_done  = !err;
    wr_error = err;
    @(negedge clk);
    wr_done  = 1'b0;
    wr_error = 1'b0;
    chk("busy_idle", 64'(busy), 0);
    chk("err_pulse", 64'(err_pulse), 64'(err));
    if (err) chk("err_src", 64'(err_src), 64'(last_exp.src));
    @(negedge clk);
    chk("err_pulse_1cyc", 64'(err_pulse), 0);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(wr_valid), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_pending"}, 64'(pending), 0);
    chk({tag, "_addr"}, 64'(wr_addr), 0);
    chk({tag, "_data"}, 64'(wr_data), 0);
    chk({tag, "_err"}, 64'(err_pulse), 0);
    chk({tag, "_err_src"}, 64'(err_src), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{SRC_CQ_I(), 4'd3,  54'h400,              32'hA5,       56'h1000,              32'hA5};
    vecs[1] = '{1,          4'd7,  54'h3F_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 56'hFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF};
    vecs[2] = '{2,          4'd15, 54'h12_3456_789A,      32'hDEAD_BEEF, 56'h48_D159_E268,      32'hDEAD_BEEF};
    vecs[3] = '{3,          4'd0,  54'h1,                 32'h0,         56'h4,                 32'h0};

    rst = 1'b1; en = 1'b1; ip = '0; mask = '0;
    wr_ready = 1'b0; wr_done = 1'b0; wr_error = 1'b0;
    iv = {4'd0, 4'd9, 4'd5, 4'd3};
    for (int v = 0; v < 16; v++) begin
      tbl_addr[v] = 54'(32'h100 + v * 16);
      tbl_data[v] = 32'hD000 + 32'(v);
    end
    @(negedge clk);
    reset_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single-source writes through each source, incl. address extremes.
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      iv[vecs[k].src]       = vecs[k].vec;
      tbl_addr[vecs[k].vec] = vecs[k].t_addr;
      tbl_data[vecs[k].vec] = vecs[k].t_data;
      e.addr = vecs[k].e_addr;
      e.data = vecs[k].e_data;
      e.src  = vecs[k].src;
      sb.push_back(e);
      ip[vecs[k].src] = 1'b1;
      wait_valid();
      handshake();
      complete(1'b0);
      chk("vec_pending_clr", 64'(pending), 0);
      ip[vecs[k].src] = 1'b0;
      @(negedge clk);
    end

    // Masked vector holds the message, issues the cycle after unmask.
    iv[1] = 4'd5;
    mask[5] = 1'b1;
    ip[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("masked_no_req", 64'(wr_valid), 0);
    chk("masked_pending", 64'(pending), 64'h2);
    mask[5] = 1'b0;
    push_exp(1);
    @(negedge clk);
    chk("unmask_next_cycle", 64'(wr_valid), 1);
    wait_valid();
    handshake();
    complete(1'b0);
    ip[1] = 1'b0;
    @(negedge clk);

    // Round robin from ptr=0 after reset: FQ, HPM, CQ.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    iv = {4'd0, 4'd9, 4'd5, 4'd3};
    ip = 4'b0111;
    push_exp(1);
    push_exp(2);
    push_exp(0);
    wait_valid();
    handshake();
    chk("rr_pending_after_fq", 64'(pending), 64'b0101);
    complete(1'b0);
    wait_valid();
    chk("rr_second_is_hpm", 64'(last_exp.src), 2);
    handshake();
    complete(1'b0);
    wait_valid();
    handshake();
    chk("rr_pending_empty", 64'(pending), 0);
    complete(1'b0);
    ip = '0;
    @(negedge clk);

    // Error completion: pulse, source reported, no retry.
    ip[2] = 1'b1;
    push_exp(2);
    wait_valid();
    handshake();
    complete(1'b1);
    chk("err_pending_clr", 64'(pending), 0);
    repeat (5) @(negedge clk);
    chk("err_no_retry", 64'(wr_valid), 0);
    chk("err_src_held", 64'(err_src), 2);
    ip[2] = 1'b0;
    @(negedge clk);

    // Re-rise during WAIT queues a second message.
    ip[0] = 1'b1;
    push_exp(0);
    wait_valid();
    handshake();
    ip[0] = 1'b0;
    @(negedge clk);
    ip[0] = 1'b1;
    @(negedge clk);
    chk("rerise_pending", 64'(pending), 64'h1);
    chk("rerise_still_wait", 64'(busy), 1);
    push_exp(0);
    complete(1'b0);
    wait_valid();
    handshake();
    complete(1'b0);
    ip[0] = 1'b0;
    @(negedge clk);

    // Rises while disabled are dropped.
    en = 1'b0;
    ip[3] = 1'b1;
    repeat (3) @(negedge clk);
    chk("dis_no_pending", 64'(pending), 0);
    chk("dis_no_req", 64'(wr_valid), 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reenable_no_req", 64'(wr_valid), 0);
    ip[3] = 1'b0;
    @(negedge clk);

    // Backpressure with iv/table changes after grant: request stays latched.
    ip[3] = 1'b1;
    push_exp(3);
    wait_valid();
    tbl_addr[iv[3]] = 54'h2A_AAAA;
    tbl_data[iv[3]] = 32'h1234_5678;
    iv[3] = 4'd7;
    en = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(wr_valid), 1);
      chk("hold_addr", 64'(wr_addr), 64'(last_exp.addr));
      chk("hold_data", 64'(wr_data), 64'(last_exp.data));
    end
    en = 1'b1;
    handshake();
    // Reset in WAIT: straight back to IDLE with everything cleared.
    rst = 1'b1;
    ip = '0;
    #1;
    reset_outputs_zero("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'(wr_valid), 0);

    // Reset in ISSUE: valid drops without a clock edge.
    ip[0] = 1'b1;
    push_exp(0);
    wait_valid();
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(wr_valid), 0);
    chk("rst_async_busy", 64'(busy), 0);
    ip = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic int SRC_CQ_I();
    return 0;
  endfunction

endmodule
